// File: rtl/mmio_defs.sv
`default_nettype none
// ============================================================================
// Package     : mmio_defs
// Description : Shared memory-mapped I/O definitions: word addresses of the
//               CPU-visible peripherals, PS/2 status bit positions and the
//               PS/2 receiver state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package mmio_defs;

    // Word addresses on the data-memory port
    localparam logic [31:0] c_addr_sw         = 32'd4096;
    localparam logic [31:0] c_addr_led        = 32'd4097;
    localparam logic [31:0] c_addr_ps2_data   = 32'd4098;
    localparam logic [31:0] c_addr_ps2_status = 32'd4099;

    // PS/2 status word layout
    localparam int c_st_not_empty = 0;
    localparam int c_st_ovf       = 1;
    localparam int c_st_perr      = 2;
    localparam int c_st_ferr      = 3;
    localparam int c_st_count_lo  = 4;
    localparam int c_st_count_hi  = 7;

    // PS/2 frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

endpackage : mmio_defs
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count. A push and a pop in
//               the same cycle both take effect, so a full FIFO can accept a
//               byte while one leaves and an empty FIFO keeps the new byte.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     c_depth = (AW+1)'(DEPTH);
    localparam logic [AW:0]     c_one   = (AW+1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A pop frees the slot the simultaneous push needs, so full only blocks a lone push
    always_comb begin
        o_full    = (r_count == c_depth);
        o_empty   = (r_count == '0);
        w_do_pop  = i_pop & ~o_empty;
        w_do_push = i_push & (~o_full | i_pop);
        o_dout    = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/ps2_mmio_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_mmio_rx
// Description : Memory-mapped PS/2 keyboard receiver. Synchronises the PS/2
//               pads, deserialises 11-bit device frames, queues good scan
//               codes in a FIFO and exposes data/status words to the CPU.
// Revision    : 1.0  initial release
// ============================================================================
module ps2_mmio_rx
    import mmio_defs::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] ADDR_DATA   = c_addr_ps2_data,
    parameter logic [31:0] ADDR_STATUS = c_addr_ps2_status,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic [31:0] mem_addr,
    input  logic        mem_wren,
    output logic        hit,
    output logic [31:0] rd_data
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] c_tlimit = TW'(TIMEOUT_CYC - 1);

    // Pad conditioning
    logic          r_clk_s1, r_clk_s2, r_clk_d;
    logic          r_dat_s1, r_dat_s2;
    logic          w_fall;

    // Frame receiver
    ps2_state_t    r_state, w_state_nxt;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_parity;
    logic [TW-1:0] r_tcnt;
    logic          w_timeout;
    logic          w_push;
    logic          w_perr_set;
    logic          w_ferr_set;

    // FIFO and CPU interface
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_hit_data;
    logic          w_hit_status;
    logic          w_pop_req;
    logic          w_clr_req;
    logic          w_ovf_set;
    logic [31:0]   w_status;
    logic          r_ovf, r_perr, r_ferr;

    // Two-stage synchronisers plus one history flop on the clock path; bus idles high
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_d & ~r_clk_s2;

    // Receiver state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stop-bit verdict and timeout abort; a real edge beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        w_timeout   = (r_state != ST_IDLE) && !w_fall && (r_tcnt == c_tlimit);
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (!r_dat_s2) begin
                        w_ferr_set = 1'b1;
                    end else if (!(^{r_shreg, r_parity})) begin
                        w_perr_set = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Bit counter, LSB-first shift register, parity capture and inactivity counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bitcnt <= 3'd0;
            r_shreg  <= 8'd0;
            r_parity <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            if (w_fall && r_state == ST_IDLE) begin
                r_bitcnt <= 3'd0;
            end else if (w_fall && r_state == ST_DATA) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shreg  <= {r_dat_s2, r_shreg[7:1]};
            end else if (w_fall && r_state == ST_PARITY) begin
                r_parity <= r_dat_s2;
            end
            if (w_fall || r_state == ST_IDLE) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop_req),
        .i_din   (r_shreg),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_hit_data   = (mem_addr == ADDR_DATA);
    assign w_hit_status = (mem_addr == ADDR_STATUS);
    assign w_pop_req    = mem_wren & w_hit_data;
    assign w_clr_req    = mem_wren & w_hit_status;
    assign w_ovf_set    = w_push & w_full & ~w_pop_req;

    // Sticky error flags: a set in the same cycle as a CPU clear wins
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_ovf_set)       r_ovf <= 1'b1;
            else if (w_clr_req)  r_ovf <= 1'b0;
            if (w_perr_set)      r_perr <= 1'b1;
            else if (w_clr_req)  r_perr <= 1'b0;
            if (w_ferr_set)      r_ferr <= 1'b1;
            else if (w_clr_req)  r_ferr <= 1'b0;
        end
    end

    // Read mux: data word, status word, or zero when the address is not ours
    always_comb begin
        w_status = 32'd0;
        w_status[c_st_not_empty]              = ~w_empty;
        w_status[c_st_ovf]                    = r_ovf;
        w_status[c_st_perr]                   = r_perr;
        w_status[c_st_ferr]                   = r_ferr;
        w_status[c_st_count_hi:c_st_count_lo] = 4'(w_count);
        hit     = w_hit_data | w_hit_status;
        rd_data = 32'd0;
        if (w_hit_data) begin
            rd_data = {23'd0, ~w_empty, w_head};
        end else if (w_hit_status) begin
            rd_data = w_status;
        end
    end

endmodule : ps2_mmio_rx
`default_nettype wire
